// File: rtl/ride_scheduler_if.sv
// ride_scheduler_if: floor-call inputs and scheduler status outputs bundled for ride_scheduler.
// Signals: call[9:0] per-floor request pulses, current[3:0] present floor,
//          target[3:0] desired floor, door_open, pending[9:0] outstanding requests,
//          dir sweep direction (1=up), busy (not idle).
// master drives call/current; slave (the scheduler) drives the status outputs.
interface ride_scheduler_if;
  logic [9:0] call;
  logic [3:0] current;
  logic [3:0] target;
  logic       door_open;
  logic [9:0] pending;
  logic       dir;
  logic       busy;
  modport master (output call, current, input target, door_open, pending, dir, busy);
  modport slave (input call, current, output target, door_open, pending, dir, busy);
endinterface

// File: rtl/ride_scheduler.sv
// ride_scheduler: SCAN elevator scheduler with IDLE/MOVE/DOOR FSM and registered outputs.
// Ports: clk, reset (sync, active-high), bus (ride_scheduler_if.slave: call, current in;
//        target, door_open, pending, dir, busy out).
// Optional: define RIDEUP_EMERGENCY_EN to add the estop input (forces IDLE, clears requests).
// Parameter: DOOR_CYCLES (1..15) cycles door_open stays high per stop.
module ride_scheduler #(
  parameter int DOOR_CYCLES = 4
) (
  input logic clk,
  input logic reset,
`ifdef RIDEUP_EMERGENCY_EN
  input logic estop,
`endif
  ride_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  state_t st, st_nx;
  logic [9:0] pending, pending_nx, oh_cur, eff;
  logic [3:0] target, target_nx, timer, timer_nx, scan_t, up_t, dn_t;
  logic dir, dir_nx, scan_dir, have_up, have_dn, door_open, busy;
  logic frozen, go_door, restart, expire;
  assign bus.target = target;
  assign bus.pending = pending;
  assign bus.dir = dir;
  assign bus.door_open = door_open;
  assign bus.busy = busy;
  // An out-of-range floor selects no bit, so every call still registers while frozen.
  assign frozen = bus.current > 4'd9;
  assign oh_cur = frozen ? '0 : 10'(1) << bus.current;
  // Calls arriving this cycle take part in target selection so a closer request retargets at once.
  assign eff = pending | bus.call;
  always_comb begin
    up_t = '0;
    dn_t = '0;
    have_up = 1'b0;
    have_dn = 1'b0;
    for (int i = 9; i >= 0; i--)
      if (eff[i] && 4'(i) > bus.current) begin
        up_t = 4'(i);
        have_up = 1'b1;
      end
    for (int i = 0; i < 10; i++)
      if (eff[i] && 4'(i) < bus.current) begin
        dn_t = 4'(i);
        have_dn = 1'b1;
      end
    scan_dir = dir ? (have_up || !have_dn) : (have_up && !have_dn);
    scan_t = (scan_dir ? have_up : have_dn) ? (scan_dir ? up_t : dn_t) : bus.current;
  end
  // IDLE also opens for a request already pending at the floor the car now sits on.
  assign go_door = !frozen && |(oh_cur & (st == IDLE ? (bus.call | pending) :
                   (st == MOVE && bus.current == target) ? pending : '0));
  assign restart = !frozen && st == DOOR && |(bus.call & oh_cur);
  assign expire = !frozen && st == DOOR && !restart && timer == '0;
  always_comb
    st_nx = frozen ? st : go_door ? DOOR : (st == IDLE || expire) ? ((|pending) ? MOVE : IDLE) : st;
  always_comb begin
    pending_nx = (pending | (bus.call & (st == DOOR ? ~oh_cur : '1))) & (go_door ? ~oh_cur : '1);
    timer_nx = frozen ? timer : (go_door || restart) ? 4'(DOOR_CYCLES - 1) :
               (st == DOOR && timer != '0) ? timer - 4'd1 : '0;
    target_nx = frozen ? target : st_nx == MOVE ? scan_t : bus.current;
    dir_nx = (!frozen && st_nx == MOVE) ? scan_dir : dir;
  end
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      pending <= '0;
      target <= '0;
      dir <= 1'b1;
      door_open <= 1'b0;
      busy <= 1'b0;
      timer <= '0;
    end
`ifdef RIDEUP_EMERGENCY_EN
    else if (estop) begin
      st <= IDLE;
      pending <= '0;
      target <= bus.current;
      door_open <= 1'b0;
      busy <= 1'b0;
      timer <= '0;
    end
`endif
    else begin
      st <= st_nx;
      pending <= pending_nx;
      target <= target_nx;
      dir <= dir_nx;
      door_open <= st_nx == DOOR;
      busy <= st_nx != IDLE;
      timer <= timer_nx;
    end
endmodule
